// File: rtl/zap_fifo_pkg.sv
// Shared constants for the zap prefetch FIFO and its RAM macro.
package zap_fifo_pkg;

  // Read latency of zap_ram_simple, from address to data.
  localparam int ZAP_RAM_RD_LAT = 2;

  // Entries in the landing buffer in front of the consumer.
  localparam int ZAP_SKID_DEPTH = 3;

endpackage

// File: rtl/zap_ram_simple.sv
// Simple dual-port RAM macro: one write port and one registered read port
// with ZAP_RAM_RD_LAT cycles of latency. A read and a write to the same
// address on the same edge return the old contents (read-before-write).
module zap_ram_simple
  import zap_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_ce,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] rd_pipe [ZAP_RAM_RD_LAT];

  // Storage write, array read and output pipeline; no reset on data.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    if (i_ce) begin
      rd_pipe[0] <= mem[i_raddr];
      for (int i = 1; i < ZAP_RAM_RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign o_rdata = rd_pipe[ZAP_RAM_RD_LAT-1];

endmodule

// File: rtl/zap_prefetch_fifo.sv
// Show-ahead FIFO backed by zap_ram_simple. Reads are issued ahead of demand
// under a credit limit so that returning data always fits the 3-entry skid
// buffer, which presents the head word to the consumer without bubbles.
module zap_prefetch_fifo
  import zap_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_wr_en,
  input  logic [WIDTH-1:0]             i_wr_data,
  output logic                         o_full,
  output logic                         o_rd_valid,
  output logic [WIDTH-1:0]             o_rd_data,
  input  logic                         i_rd_ack,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+4)-1:0]   o_level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int LW  = $clog2(DEPTH + 4);
  localparam int SW  = $clog2(ZAP_SKID_DEPTH + 1);
  localparam int CRW = SW + 1;
  localparam logic [CW-1:0]  RAM_FULL   = CW'(DEPTH);
  localparam logic [CRW-1:0] SKID_LIMIT = CRW'(ZAP_SKID_DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    ram_cnt;
  logic [CW-1:0]    ram_cnt_nxt;
  logic             full_q;
  logic [LW-1:0]    level_q;
  logic             push_acc;
  logic             pop;
  logic             rd_valid;
  logic [CRW-1:0]   credit_used;
  logic             vld_p0;
  logic             vld_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] ram_rdata_p2;
  logic [SW-1:0]    skid_cnt;
  logic [SW-1:0]    skid_wr_idx;
  logic [WIDTH-1:0] skid_data [ZAP_SKID_DEPTH];

  assign push_acc = i_wr_en & ~full_q;
  assign rd_valid = (skid_cnt != '0);
  assign pop      = i_rd_ack & rd_valid;

  // Stage p0: issue a read when the RAM holds a written word and the words
  // already in flight or in the skid, net of this cycle's pop, leave room.
  // ram_cnt only counts completed writes, so a same-cycle push is never read.
  assign credit_used = CRW'(skid_cnt) + CRW'(vld_p1) + CRW'(vld_p2) - CRW'(pop);
  assign vld_p0      = (ram_cnt != '0) && (credit_used < SKID_LIMIT);

  // RAM occupancy after this edge; push and issue together cancel out.
  always_comb begin
    ram_cnt_nxt = ram_cnt;
    case ({push_acc, vld_p0})
      2'b10:   ram_cnt_nxt = ram_cnt + CW'(1);
      2'b01:   ram_cnt_nxt = ram_cnt - CW'(1);
      default: ram_cnt_nxt = ram_cnt;
    endcase
  end

  zap_ram_simple #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_ce    (1'b1),
    .i_we    (push_acc),
    .i_waddr (wr_ptr),
    .i_wdata (i_wr_data),
    .i_raddr (rd_ptr),
    .o_rdata (ram_rdata_p2)
  );

  // Control state: pointers, counts, full flag, in-flight valids, level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      full_q   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      skid_cnt <= '0;
      level_q  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (vld_p0) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ram_cnt <= ram_cnt_nxt;
      full_q  <= (ram_cnt_nxt == RAM_FULL);
      // Stage p0 -> p1 -> p2: valid follows the RAM read latency.
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      // Stage p2: returning word lands in the skid at the end of the cycle.
      skid_cnt <= skid_cnt + SW'(vld_p2) - SW'(pop);
      level_q  <= level_q + LW'(push_acc) - LW'(pop);
    end
  end

  // Landing slot for the p2 word: just behind the entries that survive a pop.
  assign skid_wr_idx = skid_cnt - SW'(pop);

  // Skid data: shift toward the head on pop, then land the returning word.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < ZAP_SKID_DEPTH - 1; i++) begin
      if (pop) begin
        skid_data[i] <= skid_data[i+1];
      end
    end
    for (int i = 0; i < ZAP_SKID_DEPTH; i++) begin
      if (vld_p2 && (skid_wr_idx == SW'(i))) begin
        skid_data[i] <= ram_rdata_p2;
      end
    end
  end

  assign o_full     = full_q;
  assign o_rd_valid = rd_valid;
  assign o_rd_data  = rd_valid ? skid_data[0] : '0;
  assign o_level    = level_q;
  assign o_empty    = (level_q == '0);

endmodule

// File: tb/tb_zap_prefetch_fifo.sv
// Bench for zap_prefetch_fifo: a table of exact cycle-by-cycle vectors for the
// single-word latency path, directed fill/stream/reset sequences, and random
// traffic checked against a queue model of the FIFO contents.
module tb_zap_prefetch_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH + 4);
  localparam int CAP   = DEPTH + 3;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_full;
  logic             o_rd_valid;
  logic [WIDTH-1:0] o_rd_data;
  logic             i_rd_ack;
  logic             o_empty;
  logic [LW-1:0]    o_level;

  zap_prefetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_rd_ack   (i_rd_ack),
    .o_empty    (o_empty),
    .o_level    (o_level)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        ack;
    logic        exp_valid;
    logic [31:0] exp_data;
    int          exp_level;
    logic        exp_empty;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: words currently held by the FIFO and their push cycles.
  logic [31:0] mq [$];
  int          tq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset   = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_data = '0;
    i_rd_ack  = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    mq.delete();
    tq.delete();
  endtask

  // One clock of traffic checked against the queue model. A word pushed in
  // cycle p must be visible at the head by cycle p+4 at the latest.
  task automatic mcycle(input logic wr, input logic [31:0] d, input logic ack);
    logic acc;
    logic pop;
    int   pre;
    i_wr_en   = wr;
    i_wr_data = d;
    i_rd_ack  = ack;
    acc = wr & ~o_full;
    pop = ack & o_rd_valid;
    pre = cyc;
    if (o_rd_valid) begin
      chk("valid_vs_model", o_rd_valid, mq.size() != 0);
      if (mq.size() != 0) chk("head_data", o_rd_data, mq[0]);
    end else if (mq.size() != 0 && (cyc - tq[0]) >= 4) begin
      chk("head_late", o_rd_valid, 1'b1);
    end
    tick();
    if (pop && mq.size() != 0) begin
      void'(mq.pop_front());
      void'(tq.pop_front());
    end
    if (acc) begin
      mq.push_back(d);
      tq.push_back(pre);
    end
    chk("level", o_level, mq.size());
    chk("empty", o_empty, mq.size() == 0);
    chk("level_cap", o_level <= CAP, 1'b1);
    if (o_full) chk("full_level", o_level >= DEPTH, 1'b1);
    if (mq.size() == CAP) chk("full_at_cap", o_full, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [18];
    int   n;
    int   budget;
    int   pushed;
    int   popped;

    tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,         1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 1'b1};
    tbl[5]  = '{1'b1, 32'h22,        1'b1, 1'b0, 32'h0,         1, 1'b0};
    tbl[6]  = '{1'b1, 32'h33,        1'b0, 1'b0, 32'h0,         2, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         2, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h22,        2, 1'b0};
    tbl[9]  = '{1'b1, 32'h44,        1'b1, 1'b1, 32'h33,        2, 1'b0};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h33,        2, 1'b0};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h44,        1, 1'b0};
    tbl[13] = '{1'b1, 32'h55,        1'b1, 1'b0, 32'h0,         1, 1'b0};
    tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1, 1'b0};
    tbl[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1, 1'b0};
    tbl[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h55,        1, 1'b0};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_valid", o_rd_valid, 1'b0);
    chk("rst_full",  o_full,     1'b0);
    chk("rst_empty", o_empty,    1'b1);
    chk("rst_level", o_level,    0);
    chk("rst_data",  o_rd_data,  0);

    // Exact single-word latency, ack-while-invalid, push with last ack
    for (int k = 0; k < 18; k++) begin
      i_wr_en   = tbl[k].wr;
      i_wr_data = tbl[k].data;
      i_rd_ack  = tbl[k].ack;
      tick();
      chk($sformatf("vec%0d_valid", k), o_rd_valid, tbl[k].exp_valid);
      chk($sformatf("vec%0d_level", k), o_level,    tbl[k].exp_level);
      chk($sformatf("vec%0d_empty", k), o_empty,    tbl[k].exp_empty);
      if (tbl[k].exp_valid) chk($sformatf("vec%0d_data", k), o_rd_data, tbl[k].exp_data);
    end

    // Fill to DEPTH+3, drop one push at full, drain in order
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      if (i == CAP - 1) chk("full_before_last", o_full, 1'b0);
      mcycle(1'b1, i, 1'b0);
    end
    chk("fill_full",  o_full,  1'b1);
    chk("fill_level", o_level, CAP);
    mcycle(1'b1, 32'h99, 1'b0);
    chk("drop_level", o_level, CAP);
    n = 0;
    budget = 200;
    while (mq.size() != 0 && budget > 0) begin
      if (o_rd_valid) begin
        chk("drain_order", o_rd_data, n);
        n++;
      end
      mcycle(1'b0, 32'h0, 1'b1);
      budget--;
    end
    chk("drain_count", n, CAP);
    chk("drain_empty", o_empty, 1'b1);

    // Continuous push and ack: no gaps once primed
    do_reset();
    popped = 0;
    budget = 300;
    for (int i = 0; popped < 100 && budget > 0; i++) begin
      if (popped > 0) chk("stream_gap", o_rd_valid, 1'b1);
      if (o_rd_valid) begin
        chk("stream_data", o_rd_data, 32'h100 + popped);
        popped++;
      end
      mcycle(i < 100, 32'h100 + i, 1'b1);
      budget--;
    end
    chk("stream_count", popped, 100);
    chk("stream_empty", o_empty, 1'b1);

    // Random push/ack traffic against the model
    do_reset();
    pushed = 0;
    budget = 20000;
    while ((pushed < 1000 || mq.size() != 0) && budget > 0) begin
      logic wr;
      logic ack;
      wr  = (pushed < 1000) && ($urandom_range(0, 99) < 60);
      ack = (pushed < 1000) ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (wr && !o_full) pushed++;
      mcycle(wr, $urandom, ack);
      budget--;
    end
    chk("random_drained", mq.size(), 0);

    // Reset with reads in flight and words in the skid
    do_reset();
    for (int i = 0; i < 20; i++) mcycle(1'b1, 32'h2000 + i, (i >= 10));
    chk("pre_reset_valid", o_rd_valid, 1'b1);
    i_reset   = 1'b1;
    i_wr_en   = 1'b1;
    i_wr_data = 32'hDEAD_BEEF;
    i_rd_ack  = 1'b0;
    tick();
    chk("mid_rst_valid", o_rd_valid, 1'b0);
    chk("mid_rst_level", o_level,    0);
    chk("mid_rst_empty", o_empty,    1'b1);
    chk("mid_rst_full",  o_full,     1'b0);
    i_reset = 1'b0;
    mq.delete();
    tq.delete();
    mcycle(1'b1, 32'h1234, 1'b0);
    budget = 10;
    while (!o_rd_valid && budget > 0) begin
      mcycle(1'b0, 32'h0, 1'b0);
      budget--;
    end
    chk("post_rst_valid", o_rd_valid, 1'b1);
    chk("post_rst_data",  o_rd_data,  32'h1234);
    chk("post_rst_level", o_level,    1);
    mcycle(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) mcycle(1'b0, 32'h0, 1'b0);
    chk("post_rst_no_stale", o_rd_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
